procyon_rs: RTL and testbench

Reservation station that feeds one functional unit (e.g. the integer execution unit) over the FU issue interface. It buffers dispatched ops and snoops the Common Data Bus (CDB) to capture pending source operands. Each cycle it issues the oldest fully-ready op to the FU, honouring the FU stall. It sits between dispatch/rename and the FU.

---
 rtl/procyon_rs.sv | 131 +++++++++++++
 tb/tb_procyon_rs.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/procyon_rs.sv
// procyon_rs: reservation station that buffers dispatched ops, wakes them from the CDB and issues the oldest ready op to one FU
module procyon_rs #(
  parameter int OPTN_DATA_WIDTH = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_RS_DEPTH = 4,
  parameter type pcyn_op_t = logic [3:0],
  parameter type pcyn_op_is_t = logic [3:0]
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic                          i_cdb_en,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_cdb_data,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_cdb_tag,
  input  logic                          i_dispatch_en,
  input  pcyn_op_t                      i_dispatch_op,
  input  pcyn_op_is_t                   i_dispatch_op_is,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_dispatch_imm,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_dispatch_tag,
  input  logic                          i_dispatch_src_rdy [0:1],
  input  logic [OPTN_DATA_WIDTH-1:0]    i_dispatch_src_data [0:1],
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_dispatch_src_tag [0:1],
  output logic                          o_dispatch_stall,
  output logic                          o_fu_valid,
  output pcyn_op_t                      o_fu_op,
  output pcyn_op_is_t                   o_fu_op_is,
  output logic [OPTN_DATA_WIDTH-1:0]    o_fu_imm,
  output logic [OPTN_DATA_WIDTH-1:0]    o_fu_src [0:1],
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_fu_tag,
  input  logic                          i_fu_stall
);
  localparam int D = OPTN_RS_DEPTH;
  localparam int IW = $clog2(OPTN_RS_DEPTH);
  localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};
  typedef struct packed {
    pcyn_op_t                                op;
    pcyn_op_is_t                             op_is;
    logic [OPTN_DATA_WIDTH-1:0]              imm;
    logic [OPTN_ROB_IDX_WIDTH-1:0]           tag;
    logic [1:0]                              rdy;
    logic [1:0][OPTN_DATA_WIDTH-1:0]         data;
    logic [1:0][OPTN_ROB_IDX_WIDTH-1:0]      stag;
  } entry_t;
  logic [D-1:0] valid_q, valid_d;
  logic [D-1:0] older_q [D];
  logic [D-1:0] older_d [D];
  entry_t ent_q [D];
  entry_t ent_d [D];
  entry_t fu_q, fu_d, disp;
  logic fu_valid_q, fu_valid_d;
  logic [D-1:0] rdy_vec;
  logic [IW-1:0] sel, free;
  logic any_rdy, dispatch_fire, issue_fire;
  assign o_dispatch_stall = &valid_q;
  assign o_fu_valid = fu_valid_q;
  assign o_fu_op = fu_q.op;
  assign o_fu_op_is = fu_q.op_is;
  assign o_fu_imm = fu_q.imm;
  assign o_fu_tag = fu_q.tag;
  assign o_fu_src[0] = fu_q.data[0];
  assign o_fu_src[1] = fu_q.data[1];
  // older_q[i][j] means entry j is older than entry i; pick the ready entry with no older ready entry, and the lowest free slot
  always_comb begin
    sel = '0;
    free = '0;
    any_rdy = 1'b0;
    for (int i = 0; i < D; i++) rdy_vec[i] = valid_q[i] & ent_q[i].rdy[0] & ent_q[i].rdy[1];
    for (int i = 0; i < D; i++)
      if (rdy_vec[i] && !(|(rdy_vec & older_q[i]))) begin
        sel = IW'(i);
        any_rdy = 1'b1;
      end
    for (int i = D - 1; i >= 0; i--)
      if (!valid_q[i]) free = IW'(i);
  end
  // next state: CDB wakeup, issue/free, dispatch with CDB bypass, flush last so it wins
  always_comb begin
    valid_d = valid_q;
    older_d = older_q;
    ent_d = ent_q;
    fu_valid_d = fu_valid_q;
    fu_d = fu_q;
    dispatch_fire = i_dispatch_en & ~o_dispatch_stall & ~i_flush;
    issue_fire = ~i_fu_stall & ~i_flush;
    disp.op = i_dispatch_op;
    disp.op_is = i_dispatch_op_is;
    disp.imm = i_dispatch_imm;
    disp.tag = i_dispatch_tag;
    for (int s = 0; s < 2; s++) begin
      disp.stag[s] = i_dispatch_src_tag[s];
      disp.rdy[s] = i_dispatch_src_rdy[s] | (i_cdb_en & (i_dispatch_src_tag[s] == i_cdb_tag));
      disp.data[s] = i_dispatch_src_rdy[s] ? i_dispatch_src_data[s] : i_cdb_data;
    end
    for (int i = 0; i < D; i++)
      for (int s = 0; s < 2; s++)
        if (valid_q[i] && !ent_q[i].rdy[s] && i_cdb_en && ent_q[i].stag[s] == i_cdb_tag) begin
          ent_d[i].rdy[s] = 1'b1;
          ent_d[i].data[s] = i_cdb_data;
        end
    if (issue_fire) begin
      fu_valid_d = any_rdy;
      fu_d = ent_q[sel];
      if (any_rdy) valid_d[sel] = 1'b0;
    end
    if (dispatch_fire) begin
      valid_d[free] = 1'b1;
      ent_d[free] = disp;
      for (int j = 0; j < D; j++) older_d[j][free] = 1'b0;
      older_d[free] = ~(ONE << free);
    end
    if (i_flush) begin
      valid_d = '0;
      fu_valid_d = 1'b0;
    end
  end
  // state registers
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      valid_q <= '0;
      older_q <= '{default: '0};
      ent_q <= '{default: '0};
      fu_valid_q <= 1'b0;
      fu_q <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      ent_q <= ent_d;
      fu_valid_q <= fu_valid_d;
      fu_q <= fu_d;
    end
endmodule

// File: tb/tb_procyon_rs.sv
// tb_procyon_rs: table vectors, directed corner sequences and random stimulus checked against an age-ordered queue model
module tb_procyon_rs;
  localparam int D = 4;
  logic clk = 1'b0, n_rst = 1'b0;
  logic flush, cdb_en, d_en, fu_stall;
  logic [31:0] cdb_data, d_imm;
  logic [4:0] cdb_tag, d_tag;
  logic [3:0] d_op, d_is;
  logic d_rdy [0:1];
  logic [31:0] d_data [0:1];
  logic [4:0] d_stag [0:1];
  logic stall, fu_valid;
  logic [3:0] fu_op, fu_is;
  logic [31:0] fu_imm;
  logic [31:0] fu_src [0:1];
  logic [4:0] fu_tag;
  int n_tests = 0, n_fail = 0;
  typedef struct packed {
    logic [3:0] op, is;
    logic [31:0] imm;
    logic [4:0] tag;
    logic [1:0] rdy;
    logic [1:0][31:0] data;
    logic [1:0][4:0] stag;
  } m_ent_t;
  m_ent_t mq[$];
  m_ent_t m_fu;
  bit m_valid;
  typedef struct { int den, tag, fst, ev, et, es; } vec_t;
  vec_t tbl [13];

  procyon_rs dut (
    .clk(clk), .n_rst(n_rst), .i_flush(flush), .i_cdb_en(cdb_en), .i_cdb_data(cdb_data), .i_cdb_tag(cdb_tag),
    .i_dispatch_en(d_en), .i_dispatch_op(d_op), .i_dispatch_op_is(d_is), .i_dispatch_imm(d_imm), .i_dispatch_tag(d_tag),
    .i_dispatch_src_rdy(d_rdy), .i_dispatch_src_data(d_data), .i_dispatch_src_tag(d_stag),
    .o_dispatch_stall(stall), .o_fu_valid(fu_valid), .o_fu_op(fu_op), .o_fu_op_is(fu_is), .o_fu_imm(fu_imm),
    .o_fu_src(fu_src), .o_fu_tag(fu_tag), .i_fu_stall(fu_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; cdb_en = 0; cdb_data = '0; cdb_tag = '0; d_en = 0; fu_stall = 0;
    d_op = '0; d_is = '0; d_imm = '0; d_tag = '0;
    for (int s = 0; s < 2; s++) begin d_rdy[s] = 0; d_data[s] = '0; d_stag[s] = '0; end
  endtask

  task automatic set_disp(input logic [4:0] tag, input logic r0, input logic [4:0] st0, input logic [31:0] s0, input logic [31:0] s1);
    d_en = 1; d_op = 4'd0; d_is = 4'd1; d_imm = {27'd0, tag}; d_tag = tag;
    d_rdy[0] = r0; d_rdy[1] = 1; d_stag[0] = st0; d_stag[1] = '0; d_data[0] = s0; d_data[1] = s1;
  endtask

  task automatic model_edge();
    m_ent_t e;
    int hit = -1;
    bit full = (mq.size() == D);
    for (int i = 0; i < mq.size(); i++) if (hit < 0 && mq[i].rdy == 2'b11) hit = i;
    if (flush) begin
      mq.delete();
      m_valid = 0;
    end else begin
      if (!fu_stall) begin
        m_valid = (hit >= 0);
        if (hit >= 0) begin m_fu = mq[hit]; mq.delete(hit); end
      end
      if (cdb_en)
        for (int i = 0; i < mq.size(); i++)
          for (int s = 0; s < 2; s++)
            if (!mq[i].rdy[s] && mq[i].stag[s] == cdb_tag) begin mq[i].rdy[s] = 1; mq[i].data[s] = cdb_data; end
      if (d_en && !full) begin
        e.op = d_op; e.is = d_is; e.imm = d_imm; e.tag = d_tag;
        for (int s = 0; s < 2; s++) begin
          e.stag[s] = d_stag[s];
          if (!d_rdy[s] && cdb_en && d_stag[s] == cdb_tag) begin e.rdy[s] = 1; e.data[s] = cdb_data; end
          else begin e.rdy[s] = d_rdy[s]; e.data[s] = d_data[s]; end
        end
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_all(input string nm);
    chk({nm, "_stall"}, 128'(stall), 128'(mq.size() == D));
    chk({nm, "_valid"}, 128'(fu_valid), 128'(m_valid));
    if (m_valid)
      chk({nm, "_payload"}, 128'({fu_op, fu_is, fu_imm, fu_tag, fu_src[1], fu_src[0]}),
          128'({m_fu.op, m_fu.is, m_fu.imm, m_fu.tag, m_fu.data[1], m_fu.data[0]}));
  endtask

  task automatic cyc(input string nm);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(nm);
  endtask

  initial begin
    idle();
    m_valid = 0;
    #1;
    chk("reset_valid", 128'(fu_valid), 128'(0));
    chk("reset_stall", 128'(stall), 128'(0));
    @(negedge clk); @(negedge clk);
    n_rst = 1;
    // den, tag, fu_stall, expected valid, expected tag, expected stall
    tbl = '{'{1, 3, 0, 0, 0, 0}, '{0, 0, 0, 1, 3, 0}, '{0, 0, 0, 0, 0, 0},
            '{1, 10, 1, 0, 0, 0}, '{1, 11, 1, 0, 0, 0}, '{1, 12, 1, 0, 0, 0}, '{1, 13, 1, 0, 0, 1},
            '{1, 14, 1, 0, 0, 1}, '{0, 0, 0, 1, 10, 0}, '{0, 0, 0, 1, 11, 0}, '{0, 0, 0, 1, 12, 0},
            '{0, 0, 0, 1, 13, 0}, '{0, 0, 0, 0, 0, 0}};
    for (int i = 0; i < 13; i++) begin
      idle();
      if (tbl[i].den != 0) set_disp(5'(tbl[i].tag), 1, 0, 32'(tbl[i].tag + 2), 32'(tbl[i].tag + 4));
      fu_stall = (tbl[i].fst != 0);
      cyc("tbl");
      chk("tbl_valid", 128'(fu_valid), 128'(tbl[i].ev));
      chk("tbl_stall", 128'(stall), 128'(tbl[i].es));
      if (tbl[i].ev != 0) chk("tbl_tag", 128'(fu_tag), 128'(tbl[i].et));
      if (i == 1) chk("tbl_src", 128'({fu_src[0], fu_src[1]}), 128'({32'd5, 32'd7}));
    end
    // younger ready op bypasses an older waiting one, then CDB wakes the older one
    idle(); set_disp(1, 0, 9, 32'h0, 32'h11); cyc("wait1");
    idle(); set_disp(2, 1, 0, 32'h22, 32'h33); cyc("wait2");
    idle(); cyc("wait3");
    chk("order_tag2", 128'({fu_valid, fu_tag}), 128'({1'b1, 5'd2}));
    idle(); cdb_en = 1; cdb_tag = 9; cdb_data = 32'h55; cyc("wake1");
    idle(); cyc("wake2");
    chk("wake_tag1", 128'({fu_valid, fu_tag, fu_src[0]}), 128'({1'b1, 5'd1, 32'h55}));
    // FU stall holds an issued op
    idle(); cyc("gap");
    idle(); set_disp(6, 1, 0, 32'h6, 32'h60); cyc("hold_d6");
    idle(); set_disp(7, 1, 0, 32'h7, 32'h70); cyc("hold_d7");
    chk("hold_pre", 128'({fu_valid, fu_tag}), 128'({1'b1, 5'd6}));
    for (int k = 0; k < 3; k++) begin
      idle(); fu_stall = 1; cyc("hold");
      chk("hold_tag6", 128'({fu_valid, fu_tag, fu_src[0]}), 128'({1'b1, 5'd6, 32'h6}));
    end
    idle(); cyc("release");
    chk("release_tag7", 128'({fu_valid, fu_tag}), 128'({1'b1, 5'd7}));
    idle(); cyc("drain");
    // dispatch bypass from a same-cycle CDB broadcast
    idle(); set_disp(8, 0, 4, 32'h0, 32'h88); cdb_en = 1; cdb_tag = 4; cdb_data = 32'hA5; cyc("byp");
    idle(); cyc("byp_issue");
    chk("bypass", 128'({fu_valid, fu_tag, fu_src[0]}), 128'({1'b1, 5'd8, 32'hA5}));
    // flush with concurrent dispatch, overriding FU stall
    for (int k = 0; k < 3; k++) begin
      idle(); set_disp(5'(20 + k), 1, 0, 32'(k), 32'(k)); fu_stall = 1; cyc("fill");
    end
    idle(); set_disp(23, 1, 0, 32'h1, 32'h2); fu_stall = 1; flush = 1; cyc("flush");
    chk("flush_state", 128'({fu_valid, stall}), 128'(0));
    for (int k = 0; k < 3; k++) begin
      idle(); cyc("post_flush");
      chk("post_flush_valid", 128'(fu_valid), 128'(0));
    end
    // asynchronous reset while an op is issuing
    idle(); set_disp(24, 1, 0, 32'h3, 32'h4); cyc("rst_d");
    idle(); cyc("rst_issue");
    chk("rst_pre", 128'(fu_valid), 128'(1));
    #2 n_rst = 0;
    #1 chk("rst_async", 128'(fu_valid), 128'(0));
    mq.delete(); m_valid = 0;
    @(negedge clk); n_rst = 1;
    // random stimulus against the model
    for (int k = 0; k < 600; k++) begin
      idle();
      flush = ($urandom_range(99) < 3);
      fu_stall = ($urandom_range(99) < 25);
      cdb_en = $urandom_range(1);
      cdb_tag = 5'($urandom_range(7));
      cdb_data = $urandom;
      d_en = ($urandom_range(99) < 60);
      d_op = 4'($urandom); d_is = 4'($urandom); d_imm = $urandom; d_tag = 5'($urandom);
      for (int s = 0; s < 2; s++) begin
        d_rdy[s] = ($urandom_range(99) < 50);
        d_data[s] = $urandom;
        d_stag[s] = 5'($urandom_range(7));
      end
      cyc("rand");
    end
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
